truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Self-checking sequencer for combinational gate-level blocks such as p AND NOT q built from NOR primitives. On `start`, it drives every input combination onto `stim` in descending order (all-ones down to zero) and waits a programmable settle time. It then samples the DUT's `dut_result` and compares it against a parameterised truth table. It sits on the stimulus/response side of the DUT, replacing hand-written `initial` sequences with a clocked pass/fail verdict and an error count.

## Interface
- `N`, 2, number of DUT inputs (1..4)
- `EXPECTED`, 4'b0100, expected truth table (width 2^N); bit i is the expected output for `stim == i` (default encodes p AND NOT q, with p as the MSB of `stim`)
- `SETTLE`, 1, cycles each vector is held before sampling (>= 1)
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: begin a sweep; sampled only in IDLE or DONE
- `dut_result` input 1: DUT output under test
- `stim` output N: vector driven to the DUT
- `busy` output 1: sweep in progress
- `done` output 1: one-cycle pulse when the sweep completes
- `pass` output 1: 1 when the last sweep had zero mismatches
- `err_count` output N+1: mismatches in the last or current sweep
- `fail_valid` output 1: at least one mismatch has been seen this sweep
- `fail_index` output N: `stim` value of the first mismatch
- `observed` output 2^N: captured DUT responses (see Configuration)

## Operation
- Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_index`=0, `observed`=0, state=IDLE.
- FSM states are IDLE, HOLD and DONE.
- IDLE/DONE with `start`=1 → HOLD:
  - `stim` loads 2^N-1, settle counter loads SETTLE-1.
  - `err_count`, `fail_valid`, `fail_index`, `observed` and `pass` all clear.
- HOLD, counter ≠ 0 → decrement counter; `stim` is unchanged.
- HOLD, counter = 0 → sample `dut_result`:
  - A mismatch is `dut_result !== EXPECTED[stim]`, so an X or Z on `dut_result` counts as a mismatch.
  - On mismatch, `err_count` increments (it cannot saturate, max 2^N).
  - On the first mismatch only, set `fail_valid` and `fail_index`=`stim`.
  - If `stim` ≠ 0: `stim` decrements (wraps never occur) and the counter reloads SETTLE-1.
  - If `stim` = 0: go to DONE, pulse `done`, set `pass` = (final `err_count` == 0).
- DONE holds all results and the final `stim`=0 until the next `start`.
- `start` in HOLD is ignored.
- `start` held high in DONE restarts a sweep every time DONE is reached.
- Reset asserted mid-sweep: all outputs return to their reset values immediately; no partial verdict is kept.

## Timing
- `start` sampled high at edge t:
  - `busy`=1 and `stim`=2^N-1 from t+1.
  - Vector k (k = 0..2^N-1 in sweep order) is driven during cycles t+1+k·SETTLE .. t+(k+1)·SETTLE.
  - Vector k is sampled at the closing edge of that window.
- `done`=1 and `busy`=0 in cycle t+1+2^N·SETTLE. `pass`, `err_count` and `fail_*` are final in that same cycle.
- Sweep latency is 2^N·SETTLE+1 cycles from `start` to `done`. With defaults: 11 @t+1, 10 @t+2, 01 @t+3, 00 @t+4, `done` @t+5.
- Earliest restart: `start` high in the `done` cycle begins a new sweep at the next edge.

## Configuration
- `TT_CHECKER_CAPTURE_EN` defined:
  - `observed[stim]` is written with the sampled `dut_result` on every sample edge.
  - This gives the full measured truth table.
- Not defined:
  - `observed` is tied to 0 and no capture register is built.
  - All other behaviour is identical.

## Structure
- Package `truth_table_pkg`:
  - State enum (IDLE, HOLD, DONE).
  - `TT_WIDTH(n) = 1<<n` helper.
  - Default EXPECTED constants for the gate library: NOT, AND, OR, NOR, NAND, p AND NOT q.
- One sub-module, `settle_timer`:
  - Loadable down-counter with a `zero` flag, sized `$clog2(SETTLE)` (minimum 1 bit).
  - Instantiated once by the checker.

## Test plan
- Defaults with a correct NOR-built p AND NOT q DUT, `start` pulsed → `stim` sequence 11,10,01,00; `done` @t+5; `pass`=1; `err_count`=0; `fail_valid`=0.
- EXPECTED=4'b1000 (AND) against the same p AND NOT q DUT → `err_count`=2, `fail_valid`=1, `fail_index`=2'b11, `pass`=0.
- SETTLE=3, N=2 → each vector held 3 cycles; `done` @t+13; `start` during `busy` has no effect.
- `rst_n` pulled low at t+3 mid-sweep → all outputs 0 and state IDLE in the same cycle; a new `start` gives a clean sweep with `pass`=1.
- DUT output forced to X → `err_count`=4, `pass`=0.
- With `TT_CHECKER_CAPTURE_EN`, correct DUT → `observed`=4'b0100; without the macro, `observed`=0 always.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table checker: FSM states,
// the truth-table width helper and expected tables for the gate library.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  function automatic int TT_WIDTH(input int n);
    return 1 << n;
  endfunction

  // Bit i is the expected output for stim == i; the MSB of stim is operand p.
  localparam logic [1:0] TT_NOT         = 2'b01;
  localparam logic [3:0] TT_AND         = 4'b1000;
  localparam logic [3:0] TT_OR          = 4'b1110;
  localparam logic [3:0] TT_NOR         = 4'b0001;
  localparam logic [3:0] TT_NAND        = 4'b0111;
  localparam logic [3:0] TT_P_AND_NOT_Q = 4'b0100;

endpackage

// File: rtl/truth_table_checker_if.sv
// Stimulus/response bundle between the truth-table checker (master) and the
// block under test plus its controller (slave).
interface truth_table_checker_if #(
  parameter int N = 2
);
  localparam int W = truth_table_pkg::TT_WIDTH(N);

  logic         start;
  logic         dut_result;
  logic [N-1:0] stim;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic         fail_valid;
  logic [N-1:0] fail_index;
  logic [W-1:0] observed;

  modport master (
    input  start, dut_result,
    output stim, busy, done, pass, err_count, fail_valid, fail_index, observed
  );

  modport slave (
    output start, dut_result,
    input  stim, busy, done, pass, err_count, fail_valid, fail_index, observed
  );

endinterface

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter that times how long each vector is held; zero marks
// the sample cycle.
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int             CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  RELOAD = CW'(SETTLE - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input vectors (descending) into a combinational block, samples
// its response after SETTLE cycles and checks it against EXPECTED.
// Optional: define TT_CHECKER_CAPTURE_EN to record the measured truth table.
module truth_table_checker
  import truth_table_pkg::*;
#(
  parameter int                       N        = 2,
  parameter logic [TT_WIDTH(N)-1:0]   EXPECTED = TT_P_AND_NOT_Q,
  parameter int                       SETTLE   = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_checker_if.master bus
);

  localparam logic [N-1:0] STIM_TOP = {N{1'b1}};

  tt_state_e    state, next_state;
  logic         timer_zero, timer_load, timer_en;
  logic         busy, start_sweep, sample, last_vector, mismatch;
  logic [N:0]   err_next;

  logic [N-1:0] stim_q;
  logic [N-1:0] fail_index_q;
  logic [N:0]   err_q;
  logic         done_q, pass_q, fail_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: if (bus.start) next_state = HOLD;
      HOLD:       if (timer_zero && stim_q == '0) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == HOLD);
    start_sweep = (state == IDLE || state == DONE) && bus.start;
    sample      = busy && timer_zero;
    last_vector = sample && (stim_q == '0);
    // Case inequality: an X or Z response is a mismatch, never a match.
    mismatch    = sample && (bus.dut_result !== EXPECTED[stim_q]);
    timer_load  = start_sweep || (sample && !last_vector);
    timer_en    = busy;
    err_next    = err_q + (N+1)'(mismatch);
  end

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .en    (timer_en),
    .zero  (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q       <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_index_q <= '0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= last_vector;
      if (start_sweep) begin
        stim_q       <= STIM_TOP;
        err_q        <= '0;
        fail_valid_q <= 1'b0;
        fail_index_q <= '0;
        pass_q       <= 1'b0;
      end else if (sample) begin
        err_q <= err_next;
        if (mismatch && !fail_valid_q) begin
          fail_valid_q <= 1'b1;
          fail_index_q <= stim_q;
        end
        // The sweep ends on vector zero, so stim never wraps.
        if (last_vector) pass_q <= (err_next == '0);
        else             stim_q <= stim_q - N'(1);
      end
    end
  end

`ifdef TT_CHECKER_CAPTURE_EN
  logic [TT_WIDTH(N)-1:0] observed_q;

  // NOTE: the capture register is a handful of flops with a defined reset
  // value, unlike a RAM array, so it is reset with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      observed_q <= '0;
    end else if (start_sweep) begin
      observed_q <= '0;
    end else if (sample) begin
      observed_q[stim_q] <= bus.dut_result;
    end
  end

  assign bus.observed = observed_q;
`else
  assign bus.observed = '0;
`endif

  assign bus.stim       = stim_q;
  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_index = fail_index_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three instances (default, AND table, SETTLE=3)
// checked every cycle against a sweep-timeline model plus literal checkpoints.
module tb_truth_table_checker;

  typedef struct packed {
    logic [1:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err;
    logic       fv;
    logic [1:0] fi;
    logic [3:0] obs;
  } out_t;

  logic clk;
  logic rst_n;
  logic start_v [3];
  int   dut_mode [3];          // 0 correct, 1 inverted, 2 unknown (X)
  logic x_val = 1'bx;

  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: sweep start edge per instance and cycle count.
  bit         active   [3];
  int         t0       [3];
  int         mode_lat [3];
  int         cyc = 0;
  logic [3:0] exp_tt   [3] = '{4'b0100, 4'b1000, 4'b0100};
  int         settle   [3] = '{1, 1, 3};

  truth_table_checker_if #(.N(2)) if0 ();
  truth_table_checker_if #(.N(2)) if1 ();
  truth_table_checker_if #(.N(2)) if2 ();

  truth_table_checker #(.N(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  truth_table_checker #(.N(2), .EXPECTED(4'b1000)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  truth_table_checker #(.N(2), .SETTLE(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // p AND NOT q from NOR gates: nor(nor(p,p), q).
  wire np0, y0, np1, y1, np2, y2;
  nor (np0, if0.stim[1], if0.stim[1]);
  nor (y0, np0, if0.stim[0]);
  nor (np1, if1.stim[1], if1.stim[1]);
  nor (y1, np1, if1.stim[0]);
  nor (np2, if2.stim[1], if2.stim[1]);
  nor (y2, np2, if2.stim[0]);

  assign if0.dut_result = (dut_mode[0] == 2) ? x_val : ((dut_mode[0] == 1) ? ~y0 : y0);
  assign if1.dut_result = y1;
  assign if2.dut_result = y2;
  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];

  out_t act [3];
  assign act[0] = {if0.stim, if0.busy, if0.done, if0.pass, if0.err_count,
                   if0.fail_valid, if0.fail_index, if0.observed};
  assign act[1] = {if1.stim, if1.busy, if1.done, if1.pass, if1.err_count,
                   if1.fail_valid, if1.fail_index, if1.observed};
  assign act[2] = {if2.stim, if2.busy, if2.done, if2.pass, if2.err_count,
                   if2.fail_valid, if2.fail_index, if2.observed};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic dut_val(input int mode, input int idx);
    logic base;
    base = (idx == 2);
    case (mode)
      1:       return ~base;
      2:       return x_val;
      default: return base;
    endcase
  endfunction

  // Expected outputs j cycles after the accepting edge: vector k is held for
  // cycles k*S+1 .. (k+1)*S and counted once its window has closed.
  function automatic out_t model(input int d);
    out_t e;
    int   j, s, sampled, v;
    logic r;
    e = '0;
    if (!active[d]) return e;
    s = settle[d];
    j = cyc - t0[d];
    if (j <= 4 * s) begin
      e.busy  = 1'b1;
      e.stim  = 2'(3 - (j - 1) / s);
      sampled = (j - 1) / s;
    end else begin
      sampled = 4;
      e.done  = (j == 4 * s + 1);
    end
    for (int k = 0; k < sampled; k++) begin
      v = 3 - k;
      r = dut_val(mode_lat[d], v);
      if (r !== exp_tt[d][v]) begin
        if (!e.fv) begin
          e.fv = 1'b1;
          e.fi = 2'(v);
        end
        e.err = e.err + 3'd1;
      end
`ifdef TT_CHECKER_CAPTURE_EN
      e.obs[v] = r;
`endif
    end
    if (!e.busy) e.pass = (e.err == 3'd0);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) active[d] <= 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (start_v[d] && !(active[d] && (cyc - t0[d]) >= 1 && (cyc - t0[d]) <= 4 * settle[d])) begin
          active[d]   <= 1'b1;
          t0[d]       <= cyc;
          mode_lat[d] <= dut_mode[d];
        end
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin : compare
    out_t e;
    for (int d = 0; d < 3; d++) begin
      e = model(d);
      check($sformatf("d%0d stim", d),       act[d].stim, e.stim);
      check($sformatf("d%0d busy", d),       act[d].busy, e.busy);
      check($sformatf("d%0d done", d),       act[d].done, e.done);
      check($sformatf("d%0d pass", d),       act[d].pass, e.pass);
      check($sformatf("d%0d err_count", d),  act[d].err,  e.err);
      check($sformatf("d%0d fail_valid", d), act[d].fv,   e.fv);
      check($sformatf("d%0d fail_index", d), act[d].fi,   e.fi);
      check($sformatf("d%0d observed", d),   act[d].obs,  e.obs);
    end
  end

  logic [1:0] stim_log [4];

  task automatic sweep(input int d, input int extra, output int lat);
    lat = 0;
    @(posedge clk); #1 start_v[d] = 1'b1;
    @(posedge clk); #1 start_v[d] = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (d == 0 && i <= 4) stim_log[i-1] = act[0].stim;
      if (i == extra) start_v[d] = 1'b1;
      else if (i == extra + 1) start_v[d] = 1'b0;
      if (act[d].done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat, lat2;
  logic [3:0] obs_good;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_v[d]  = 1'b0;
      dut_mode[d] = 0;
    end
`ifdef TT_CHECKER_CAPTURE_EN
    obs_good = 4'b0100;
`else
    obs_good = 4'b0000;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset stim",       act[0].stim, 0);
    check("reset busy",       act[0].busy, 0);
    check("reset done",       act[0].done, 0);
    check("reset pass",       act[0].pass, 0);
    check("reset err_count",  act[0].err,  0);
    check("reset fail_valid", act[0].fv,   0);
    check("reset observed",   act[0].obs,  0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Correct DUT, default table.
    sweep(0, 0, lat);
    check("default latency", lat, 5);
    check("default stim k0", stim_log[0], 2'b11);
    check("default stim k1", stim_log[1], 2'b10);
    check("default stim k2", stim_log[2], 2'b01);
    check("default stim k3", stim_log[3], 2'b00);
    check("default pass",       act[0].pass, 1);
    check("default err_count",  act[0].err,  0);
    check("default fail_valid", act[0].fv,   0);
    check("default observed",   act[0].obs,  obs_good);
    check("default busy at done", act[0].busy, 0);

    // start held high: DONE immediately restarts.
    @(posedge clk); #1 start_v[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (act[0].done === 1'b1) begin lat = i; break; end
    end
    lat2 = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (act[0].done === 1'b1) begin lat2 = i; break; end
    end
    start_v[0] = 1'b0;
    check("held start restart latency", lat2, 5);

    // AND table against the p AND NOT q block.
    sweep(1, 0, lat);
    check("and latency",    lat, 5);
    check("and err_count",  act[1].err, 2);
    check("and fail_valid", act[1].fv,  1);
    check("and fail_index", act[1].fi,  2'b11);
    check("and pass",       act[1].pass, 0);

    // SETTLE=3, with an ignored start pulse mid-sweep.
    sweep(2, 4, lat);
    check("settle3 latency", lat, 13);
    check("settle3 pass",    act[2].pass, 1);
    repeat (3) @(negedge clk);
    check("settle3 idle after done", act[2].busy, 0);

    // Always-wrong DUT.
    dut_mode[0] = 1;
    sweep(0, 0, lat);
    check("invert err_count",  act[0].err,  4);
    check("invert pass",       act[0].pass, 0);
    check("invert fail_index", act[0].fi,   2'b11);

    // Reset in cycle t+3 of a failing sweep.
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre-reset err_count", act[0].err,  2);
    check("pre-reset busy",      act[0].busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid reset busy",       act[0].busy, 0);
    check("mid reset stim",       act[0].stim, 0);
    check("mid reset err_count",  act[0].err,  0);
    check("mid reset fail_valid", act[0].fv,   0);
    check("mid reset fail_index", act[0].fi,   0);
    check("mid reset pass",       act[0].pass, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    dut_mode[0] = 0;
    sweep(0, 0, lat);
    check("post-reset latency",   lat, 5);
    check("post-reset pass",      act[0].pass, 1);
    check("post-reset err_count", act[0].err,  0);
    check("post-reset observed",  act[0].obs,  obs_good);

    // Unknown response on every vector.
    dut_mode[0] = 2;
    sweep(0, 0, lat);
    check("x latency", lat, 5);
    dut_mode[0] = 0;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
